// File: rtl/xtbm_arbiter_pkg.sv
// Shared codes for the xfer_buffer/TBM port arbiter: XTBM mode, FSM states and
// transfer direction.
package xtbm_arbiter_pkg;

  typedef enum logic [1:0] {
    XTBM_NOTHING = 2'd0,
    XTBM_READING = 2'd1,
    XTBM_WRITING = 2'd2
  } xtbm_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TURN = 3'd1,
    ST_SCAN = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } xtbm_state_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } xtbm_dir_e;

  function automatic xtbm_mode_e mode_of(input xtbm_dir_e dir);
    return (dir == DIR_WRITE) ? XTBM_WRITING : XTBM_READING;
  endfunction

endpackage

// File: rtl/xtbm_next_chunk.sv
// Find-first-set over the chunk mask, ignoring bits below the current index.
module xtbm_next_chunk
  import xtbm_arbiter_pkg::*;
#(
  parameter int MAX_CHUNKS = 8,
  parameter int IDX_W      = 3
) (
  input  logic [MAX_CHUNKS-1:0] mask,
  input  logic [IDX_W-1:0]      idx,
  output logic                  found,
  output logic [IDX_W-1:0]      k
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    found = 1'b0;
    k     = '0;
    for (int i = MAX_CHUNKS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(idx))) begin
        found = 1'b1;
        k     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/xtbm_arbiter.sv
// Arbitrates the xfer_buffer/TBM port between the write and read paths and walks
// each burst's chunk mask. Optional WAIT timeout: define XTBM_TIMEOUT_EN.
module xtbm_arbiter
  import xtbm_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_CHUNKS   = 8,
  parameter int STRIDE_SHIFT = 12,
  parameter int TURNAROUND   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int XFER_TIMEOUT = 1024
) (
  input  logic                  clock_fpga,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [MAX_CHUNKS-1:0] wr_valid_bits,
  input  logic [ADDR_W-1:0]     wr_base,
  output logic                  wr_grant,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [MAX_CHUNKS-1:0] rd_valid_bits,
  input  logic [ADDR_W-1:0]     rd_base,
  output logic                  rd_grant,
  output logic                  rd_done,
  output logic                  xfer_buf_select,
  output logic                  mwrite_enable,
  output logic [ADDR_W-1:0]     tbm_address,
  input  logic                  xfer_complete,
  output logic [1:0]            xtbm_mode,
  output logic                  timeout_err
);

  localparam int IDX_W    = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam int TURN_W   = $clog2(TURNAROUND + 1);
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  if (TURNAROUND < 1 || XFER_TIMEOUT < 1 || MAX_CHUNKS < 2) begin : g_bad_params
    $error("xtbm_arbiter: TURNAROUND, XFER_TIMEOUT must be >= 1 and MAX_CHUNKS >= 2");
  end

  xtbm_state_e             state_q, state_d;
  xtbm_dir_e               dir_q, dir_d, last_dir_q, last_dir_d, win_dir;
  xtbm_mode_e              mode_q, mode_d;
  logic [STREAK_W-1:0]     streak_q, streak_d;
  logic [TURN_W-1:0]       turn_cnt_q, turn_cnt_d;
  logic [MAX_CHUNKS-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]       base_q, base_d, addr_q, addr_d;
  logic [IDX_W-1:0]        idx_q, idx_d, next_k;
  logic                    next_found, win_write;
  logic                    wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic                    wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                    select_q, select_d, mwrite_q, mwrite_d;

`ifdef XTBM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(XFER_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
`endif

  xtbm_next_chunk #(
    .MAX_CHUNKS (MAX_CHUNKS),
    .IDX_W      (IDX_W)
  ) u_next_chunk (
    .mask  (mask_q),
    .idx   (idx_q),
    .found (next_found),
    .k     (next_k)
  );

  // NOTE: every signal this block writes gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    mode_d     = mode_q;
    streak_d   = streak_q;
    turn_cnt_d = turn_cnt_q;
    mask_d     = mask_q;
    base_d     = base_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    wr_grant_d = wr_grant_q;
    rd_grant_d = rd_grant_q;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    select_d   = select_q;
    mwrite_d   = mwrite_q;
    win_write  = 1'b0;
    win_dir    = DIR_READ;
`ifdef XTBM_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          // Contention favours the previous direction until the streak saturates.
          if (wr_req && rd_req) begin
            if (streak_q >= STREAK_W'(STARVE_LIMIT)) win_write = (last_dir_q != DIR_WRITE);
            else                                      win_write = (last_dir_q == DIR_WRITE);
          end else begin
            win_write = wr_req;
          end
          win_dir    = win_write ? DIR_WRITE : DIR_READ;
          dir_d      = win_dir;
          mask_d     = win_write ? wr_valid_bits : rd_valid_bits;
          base_d     = win_write ? wr_base : rd_base;
          wr_grant_d = win_write;
          rd_grant_d = !win_write;
          idx_d      = '0;
          if (win_dir != last_dir_q) begin
            state_d    = ST_TURN;
            turn_cnt_d = '0;
            streak_d   = STREAK_W'(1);
          end else begin
            state_d = ST_SCAN;
            mode_d  = mode_of(win_dir);
            if (streak_q < STREAK_W'(STARVE_LIMIT)) streak_d = streak_q + 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == TURN_W'(TURNAROUND - 1)) begin
          state_d = ST_SCAN;
          mode_d  = mode_of(dir_q);
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      ST_SCAN: begin
        if (next_found) begin
          select_d = 1'b1;
          mwrite_d = (dir_q == DIR_WRITE);
          addr_d   = base_q + (ADDR_W'(next_k) << STRIDE_SHIFT);
          idx_d    = next_k;
          state_d  = ST_WAIT;
`ifdef XTBM_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_WAIT: begin
        if (xfer_complete) begin
          select_d = 1'b0;
          mwrite_d = 1'b0;
          idx_d    = idx_q + 1'b1;
          state_d  = (idx_q == IDX_W'(MAX_CHUNKS - 1)) ? ST_DONE : ST_SCAN;
        end
`ifdef XTBM_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_W'(XFER_TIMEOUT - 1)) begin
          select_d  = 1'b0;
          mwrite_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        wr_done_d  = wr_grant_q;
        rd_done_d  = rd_grant_q;
        wr_grant_d = 1'b0;
        rd_grant_d = 1'b0;
        last_dir_d = dir_q;
        mode_d     = XTBM_NOTHING;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_READ;
      last_dir_q <= DIR_READ;
      mode_q     <= XTBM_NOTHING;
      streak_q   <= '0;
      turn_cnt_q <= '0;
      mask_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      select_q   <= 1'b0;
      mwrite_q   <= 1'b0;
`ifdef XTBM_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      mode_q     <= mode_d;
      streak_q   <= streak_d;
      turn_cnt_q <= turn_cnt_d;
      mask_q     <= mask_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      select_q   <= select_d;
      mwrite_q   <= mwrite_d;
`ifdef XTBM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign wr_grant        = wr_grant_q;
  assign rd_grant        = rd_grant_q;
  assign wr_done         = wr_done_q;
  assign rd_done         = rd_done_q;
  assign xfer_buf_select = select_q;
  assign mwrite_enable   = mwrite_q;
  assign tbm_address     = addr_q;
  assign xtbm_mode       = mode_q;
`ifdef XTBM_TIMEOUT_EN
  assign timeout_err     = timeout_q;
`else
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_xtbm_arbiter.sv
// Directed self-checking bench for xtbm_arbiter; the timeout scenario follows
// XTBM_TIMEOUT_EN.
module tb_xtbm_arbiter;
  import xtbm_arbiter_pkg::*;

  logic        clock_fpga = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0, rd_req = 1'b0, xfer_complete = 1'b0;
  logic [7:0]  wr_valid_bits = '0, rd_valid_bits = '0;
  logic [31:0] wr_base = '0, rd_base = '0;
  logic        wr_grant, wr_done, rd_grant, rd_done;
  logic        xfer_buf_select, mwrite_enable, timeout_err;
  logic [31:0] tbm_address;
  logic [1:0]  xtbm_mode;

  int n_assert = 0;
  int n_fail   = 0;

  xtbm_arbiter #(
    .ADDR_W(32), .MAX_CHUNKS(8), .STRIDE_SHIFT(12),
    .TURNAROUND(2), .STARVE_LIMIT(4), .XFER_TIMEOUT(16)
  ) dut (
    .clock_fpga      (clock_fpga),
    .reset           (reset),
    .wr_req          (wr_req),
    .wr_valid_bits   (wr_valid_bits),
    .wr_base         (wr_base),
    .wr_grant        (wr_grant),
    .wr_done         (wr_done),
    .rd_req          (rd_req),
    .rd_valid_bits   (rd_valid_bits),
    .rd_base         (rd_base),
    .rd_grant        (rd_grant),
    .rd_done         (rd_done),
    .xfer_buf_select (xfer_buf_select),
    .mwrite_enable   (mwrite_enable),
    .tbm_address     (tbm_address),
    .xfer_complete   (xfer_complete),
    .xtbm_mode       (xtbm_mode),
    .timeout_err     (timeout_err)
  );

  always #5 clock_fpga = ~clock_fpga;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_fpga);
    #1;
  endtask

  task automatic wait_select(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (xfer_buf_select) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input bit is_wr, input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (is_wr ? wr_done : rd_done) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic serve_chunk(input string tag, input logic [31:0] exp_addr,
                             input logic exp_mw, input xtbm_mode_e exp_mode);
    bit ok;
    wait_select(16, ok);
    check({tag, "_select"}, ok, 1'b1);
    check({tag, "_addr"}, tbm_address, exp_addr);
    check({tag, "_mwrite"}, mwrite_enable, exp_mw);
    check({tag, "_mode"}, xtbm_mode, exp_mode);
    xfer_complete = 1'b1;
    tick();
    xfer_complete = 1'b0;
    check({tag, "_select_drop"}, xfer_buf_select, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  wr_bursts;
    int  sel_cycles;
    bit  ok, overlap, saw_done, saw_sel;

    // Reset state
    tick();
    tick();
    check("rst_wr_grant", wr_grant, 1'b0);
    check("rst_rd_grant", rd_grant, 1'b0);
    check("rst_done", {wr_done, rd_done}, 2'b00);
    check("rst_select", xfer_buf_select, 1'b0);
    check("rst_mwrite", mwrite_enable, 1'b0);
    check("rst_addr", tbm_address, 32'h0);
    check("rst_mode", xtbm_mode, XTBM_NOTHING);
    check("rst_timeout", timeout_err, 1'b0);
    reset = 1'b0;

    // Write-only burst, mask 0000_0101: direction change from READ costs a turnaround
    wr_valid_bits = 8'b0000_0101;
    wr_base       = 32'h0000_1000;
    wr_req        = 1'b1;
    tick();
    check("w_grant", wr_grant, 1'b1);
    check("w_rd_grant", rd_grant, 1'b0);
    check("w_turn0_mode", xtbm_mode, XTBM_NOTHING);
    tick();
    check("w_turn1_mode", xtbm_mode, XTBM_NOTHING);
    tick();
    check("w_scan_mode", xtbm_mode, XTBM_WRITING);
    check("w_scan_select", xfer_buf_select, 1'b0);
    serve_chunk("w_c0", 32'h0000_1000, 1'b1, XTBM_WRITING);
    serve_chunk("w_c2", 32'h0000_3000, 1'b1, XTBM_WRITING);
    wait_done(1'b1, 10, cyc);
    check("w_done_latency", cyc, 2);
    check("w_done_grant", wr_grant, 1'b0);
    check("w_done_mode", xtbm_mode, XTBM_NOTHING);
    wr_req = 1'b0;
    tick();
    check("w_done_pulse", wr_done, 1'b0);

    // Simultaneous requests after reset: read first, write after turnaround
    do_reset();
    rd_valid_bits = 8'h80;
    rd_base       = 32'hFFFF_C000;
    wr_valid_bits = 8'h00;
    wr_req        = 1'b1;
    rd_req        = 1'b1;
    tick();
    check("both_rd_grant", rd_grant, 1'b1);
    check("both_wr_grant", wr_grant, 1'b0);
    check("both_rd_mode", xtbm_mode, XTBM_READING);
    serve_chunk("r_c7", 32'h0000_3000, 1'b0, XTBM_READING);
    wait_done(1'b0, 10, cyc);
    check("r_c7_done_latency", cyc, 1);
    check("r_done_wr_grant", wr_grant, 1'b0);
    rd_req = 1'b0;
    tick();
    check("turn_wr_grant", wr_grant, 1'b1);
    check("turn0_mode", xtbm_mode, XTBM_NOTHING);
    tick();
    check("turn1_mode", xtbm_mode, XTBM_NOTHING);
    tick();
    check("post_turn_mode", xtbm_mode, XTBM_WRITING);
    wait_done(1'b1, 10, cyc);
    check("w_empty_done_latency", cyc, 2);
    wr_req = 1'b0;

    // Starvation bound: write held while read pends
    do_reset();
    wr_valid_bits = 8'h00;
    rd_valid_bits = 8'h00;
    wr_req = 1'b1;
    tick();
    check("starve_first_grant", wr_grant, 1'b1);
    rd_req    = 1'b1;
    wr_bursts = 0;
    overlap   = 1'b0;
    ok        = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (wr_grant && rd_grant) overlap = 1'b1;
      if (wr_done) wr_bursts++;
      if (rd_grant) begin
        ok = 1'b1;
        break;
      end
    end
    check("starve_rd_granted", ok, 1'b1);
    check("starve_wr_bursts", wr_bursts, 4);
    check("starve_overlap", overlap, 1'b0);
    wr_req = 1'b0;
    wait_done(1'b0, 20, cyc);
    check("starve_rd_done_latency", cyc, 4);

    // Empty read mask, same direction: grant, then done two cycles later
    tick();
    check("empty_grant", rd_grant, 1'b1);
    check("empty_done0", rd_done, 1'b0);
    tick();
    check("empty_grant_held", rd_grant, 1'b1);
    check("empty_select", xfer_buf_select, 1'b0);
    check("empty_done1", rd_done, 1'b0);
    tick();
    check("empty_done", rd_done, 1'b1);
    check("empty_grant_drop", rd_grant, 1'b0);
    check("empty_select_done", xfer_buf_select, 1'b0);
    rd_req = 1'b0;

    // Reset during WAIT of a 3-chunk read burst
    rd_valid_bits = 8'b0000_1110;
    rd_base       = 32'h2000_0000;
    rd_req        = 1'b1;
    wait_select(10, ok);
    check("abort_select", ok, 1'b1);
    check("abort_addr", tbm_address, 32'h2000_1000);
    tick();
    reset  = 1'b1;
    rd_req = 1'b0;
    tick();
    check("abort_grant", {wr_grant, rd_grant}, 2'b00);
    check("abort_select_clr", xfer_buf_select, 1'b0);
    check("abort_addr_clr", tbm_address, 32'h0);
    check("abort_mode", xtbm_mode, XTBM_NOTHING);
    reset    = 1'b0;
    saw_done = rd_done;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_done = saw_done | rd_done | wr_done;
    end
    check("abort_no_done", saw_done, 1'b0);
    rd_req = 1'b1;
    serve_chunk("fresh_c1", 32'h2000_1000, 1'b0, XTBM_READING);
    serve_chunk("fresh_c2", 32'h2000_2000, 1'b0, XTBM_READING);
    serve_chunk("fresh_c3", 32'h2000_3000, 1'b0, XTBM_READING);
    wait_done(1'b0, 10, cyc);
    check("fresh_done_latency", cyc, 2);
    rd_req = 1'b0;

    // Stalled transfer: xfer_complete held low
    rd_valid_bits = 8'b0000_0011;
    rd_base       = 32'h0000_8000;
    rd_req        = 1'b1;
    wait_select(10, ok);
    check("stall_select", ok, 1'b1);
`ifdef XTBM_TIMEOUT_EN
    sel_cycles = 1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!xfer_buf_select) break;
      sel_cycles++;
    end
    check("to_select_cycles", sel_cycles, 16);
    check("to_err", timeout_err, 1'b1);
    saw_sel = 1'b0;
    cyc     = -1;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw_sel = saw_sel | xfer_buf_select;
      if (rd_done) begin
        cyc = i + 1;
        break;
      end
    end
    check("to_done_latency", cyc, 1);
    check("to_skip_chunks", saw_sel, 1'b0);
    rd_req = 1'b0;
    tick();
    tick();
    check("to_err_sticky", timeout_err, 1'b1);
    do_reset();
    check("to_err_reset", timeout_err, 1'b0);
`else
    for (int i = 0; i < 40; i++) tick();
    check("stall_select_held", xfer_buf_select, 1'b1);
    check("stall_addr_held", tbm_address, 32'h0000_8000);
    check("stall_no_timeout", timeout_err, 1'b0);
    xfer_complete = 1'b1;
    tick();
    xfer_complete = 1'b0;
    serve_chunk("stall_c1", 32'h0000_9000, 1'b0, XTBM_READING);
    wait_done(1'b0, 10, cyc);
    check("stall_done_latency", cyc, 2);
    rd_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
